// File: rtl/prefetch_queue_if.sv
// Code-fetch bus between the prefetch queue and the memory controller.
//   fetch_req   request, held until fetch_ack
//   fetch_addr  physical code address, stable while fetch_req=1
//   fetch_byte  1: single byte at an odd address on fetch_data[15:8]; 0: word
//   fetch_ack   fetch complete, fetch_data valid this cycle
//   fetch_data  [7:0]=byte at even address, [15:8]=byte at address|1
// Modports: master = prefetch queue, slave = memory controller.
interface prefetch_queue_if #(
    parameter int unsigned ADDR_WIDTH = 20
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_byte;
    logic                  fetch_ack;
    logic [15:0]           fetch_data;

    modport master (
        output fetch_req,
        output fetch_addr,
        output fetch_byte,
        input  fetch_ack,
        input  fetch_data
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        input  fetch_byte,
        output fetch_ack,
        output fetch_data
    );
endinterface

// File: rtl/prefetch_queue.sv
// 8086-style instruction prefetch queue and fetch sequencer.
// Issues byte/word code fetches, buffers up to QUEUE_DEPTH bytes, presents the oldest four
// bytes to decode, retires consumed bytes and flushes on a jump.
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   flush, flush_addr   discard the queue and restart fetching at flush_addr
//   fetch_hold          (PREFETCH_HOLD_EN only) suppress new fetch issue while high
//   bus                 code-fetch bus, master side (see prefetch_queue_if)
//   window              {byte3,byte2,byte1,byte0}, byte0 oldest; bytes >= count are don't-care
//   count               valid bytes in the queue
//   consume             bytes retired by decode this cycle
//   consume_err         one-cycle pulse when consume exceeded count (request ignored)
// Configuration macro: PREFETCH_HOLD_EN adds the fetch_hold input.
// count is 3 bits wide, so QUEUE_DEPTH must be an even value in 4..6.
module prefetch_queue #(
    parameter int unsigned            QUEUE_DEPTH = 6,
    parameter int unsigned            ADDR_WIDTH  = 20,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = 20'hFFFF0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_addr,
`ifdef PREFETCH_HOLD_EN
    input  logic                  fetch_hold,
`endif
    prefetch_queue_if.master      bus,
    output logic [31:0]           window,
    output logic [2:0]            count,
    input  logic [2:0]            consume,
    output logic                  consume_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    localparam logic [2:0] Depth = 3'(QUEUE_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;   // flush target held during DISCARD
    logic [2:0]            count_q, count_d;
    logic                  err_q, err_d;
    logic [7:0]            queue_q [QUEUE_DEPTH];
    logic [7:0]            queue_d [QUEUE_DEPTH];

    logic       can_issue;
    logic       fill_en;
    logic       fill_byte;
    logic [2:0] fill_n;
    logic [2:0] room;
    logic [2:0] need;
    logic       cons_bad;
    logic [2:0] retire;
    logic [2:0] keep;
    int         src;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= RESET_ADDR;
            redirect_q <= RESET_ADDR;
            count_q    <= 3'd0;
            err_q      <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            redirect_q <= redirect_d;
            count_q    <= count_d;
            err_q      <= err_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end

    // Next-state: FSM, fetch pointer, queue shift/fill and count.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        redirect_d = redirect_q;
        src        = 0;

        // Room check uses the registered count; a consume only ever adds room, so a fill
        // landing while the fetch is outstanding can never overflow.
        room      = Depth - count_q;
        need      = addr_q[0] ? 3'd1 : 3'd2;
        can_issue = (room >= need);
`ifdef PREFETCH_HOLD_EN
        can_issue = can_issue && !fetch_hold;
`endif

        // An odd fetch address is always a single-byte fetch.
        fill_byte = addr_q[0];
        fill_n    = fill_byte ? 3'd1 : 3'd2;
        fill_en   = (state_q == StFetch) && bus.fetch_ack && !flush;

        cons_bad = (consume > count_q);
        retire   = (flush || cons_bad) ? 3'd0 : consume;
        keep     = count_q - retire;

        // Shift out retired bytes, then append fill bytes directly behind the retained ones.
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            src = i + int'(retire);
            queue_d[i] = (src < QUEUE_DEPTH) ? queue_q[src] : 8'h00;
            if (fill_en) begin
                if (fill_byte) begin
                    if (i == int'(keep)) queue_d[i] = bus.fetch_data[15:8];
                end else begin
                    if (i == int'(keep))     queue_d[i] = bus.fetch_data[7:0];
                    if (i == int'(keep) + 1) queue_d[i] = bus.fetch_data[15:8];
                end
            end
        end

        count_d = flush ? 3'd0 : (keep + (fill_en ? fill_n : 3'd0));
        err_d   = !flush && cons_bad;

        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    addr_d = flush_addr;
                end else if (can_issue) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (bus.fetch_ack) begin
                    // A flush coinciding with the ack needs no discard: the cycle is done.
                    state_d = StIdle;
                    addr_d  = flush ? flush_addr
                                    : addr_q + (fill_byte ? ADDR_WIDTH'(1) : ADDR_WIDTH'(2));
                end else if (flush) begin
                    state_d    = StDiscard;
                    redirect_d = flush_addr;
                end
            end
            StDiscard: begin
                if (bus.fetch_ack) begin
                    state_d = StIdle;
                    addr_d  = flush ? flush_addr : redirect_q;
                end else if (flush) begin
                    redirect_d = flush_addr;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // fetch_addr stays at the in-flight address through DISCARD, so the bus cycle is never
    // altered mid-flight; the redirect is applied only on the ack.
    always_comb begin
        bus.fetch_req  = (state_q != StIdle);
        bus.fetch_addr = addr_q;
        bus.fetch_byte = (state_q != StIdle) && addr_q[0];
        window         = {queue_q[3], queue_q[2], queue_q[1], queue_q[0]};
        count          = count_q;
        consume_err    = err_q;
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: table-driven vectors with constant expectations,
// a byte-queue scoreboard filled on acks and drained on consumes, plus hand-written corner
// sequences (flush, discard, same-cycle consume/fill, consume error, wrap, reset mid-fetch).
module tb_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [19:0] flush_addr;
    logic [2:0]  consume;
    logic [31:0] window;
    logic [2:0]  count;
    logic        consume_err;
`ifdef PREFETCH_HOLD_EN
    logic        fetch_hold = 1'b0;
`endif

    always #5 clock = ~clock;

    prefetch_queue_if #(.ADDR_WIDTH(20)) bus ();

    prefetch_queue #(
        .QUEUE_DEPTH (6),
        .ADDR_WIDTH  (20),
        .RESET_ADDR  (20'hFFFF0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .flush_addr  (flush_addr),
`ifdef PREFETCH_HOLD_EN
        .fetch_hold  (fetch_hold),
`endif
        .bus         (bus.master),
        .window      (window),
        .count       (count),
        .consume     (consume),
        .consume_err (consume_err)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard / reference model state
    logic [7:0]  sb [$];
    logic        m_busy;
    logic        m_discard;
    logic [19:0] m_addr;
    logic [19:0] m_redirect;
    logic        m_err;

    typedef struct {
        logic        fl;
        logic [19:0] fa;
        logic        ack;
        logic [15:0] data;
        logic [2:0]  cons;
        logic        exp_req;
        logic [19:0] exp_addr;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_const(input string tag, input logic req, input logic [19:0] addr,
                                input logic [2:0] cnt);
        chk({tag, "_req"}, 32'(bus.fetch_req), 32'(req));
        chk({tag, "_addr"}, 32'(bus.fetch_addr), 32'(addr));
        chk({tag, "_count"}, 32'(count), 32'(cnt));
    endtask

    // Drive one cycle of stimulus, advance the model, then compare against the scoreboard.
    task automatic step(input logic fl, input logic [19:0] fa, input logic ack,
                        input logic [15:0] d, input logic [2:0] cons);
        int sz;
        int room;
        int lim;
        flush         = fl;
        flush_addr    = fa;
        bus.fetch_ack = ack;
        bus.fetch_data = d;
        consume       = cons;

        sz    = sb.size();
        room  = 6 - sz;
        m_err = 1'b0;
        if (fl) begin
            sb.delete();
        end else begin
            if (int'(cons) > sz) m_err = 1'b1;
            else for (int i = 0; i < int'(cons); i++) void'(sb.pop_front());
            if (m_busy && ack && !m_discard) begin
                if (m_addr[0]) begin
                    sb.push_back(d[15:8]);
                end else begin
                    sb.push_back(d[7:0]);
                    sb.push_back(d[15:8]);
                end
            end
        end

        if (m_busy) begin
            if (ack) begin
                m_busy = 1'b0;
                if (fl)             m_addr = fa;
                else if (m_discard) m_addr = m_redirect;
                else                m_addr = m_addr + (m_addr[0] ? 20'd1 : 20'd2);
                m_discard = 1'b0;
            end else if (fl) begin
                m_discard  = 1'b1;
                m_redirect = fa;
            end
        end else begin
            if (fl) m_addr = fa;
            else if (room >= (m_addr[0] ? 1 : 2)) m_busy = 1'b1;
        end

        @(posedge clock);
        #1;
        flush         = 1'b0;
        bus.fetch_ack = 1'b0;
        consume       = 3'd0;

        chk("sb_fetch_req", 32'(bus.fetch_req), 32'(m_busy));
        if (m_busy) begin
            chk("sb_fetch_addr", 32'(bus.fetch_addr), 32'(m_addr));
            chk("sb_fetch_byte", 32'(bus.fetch_byte), 32'(m_addr[0]));
        end
        chk("sb_count", 32'(count), 32'(sb.size()));
        lim = (sb.size() < 4) ? sb.size() : 4;
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("sb_window_b%0d", i), 32'(window[8*i +: 8]), 32'(sb[i]));
        end
        chk("sb_consume_err", 32'(consume_err), 32'(m_err));
    endtask

    task automatic model_reset();
        sb.delete();
        m_busy     = 1'b0;
        m_discard  = 1'b0;
        m_addr     = 20'hFFFF0;
        m_redirect = 20'hFFFF0;
        m_err      = 1'b0;
    endtask

    initial begin
        //            fl  fa  ack data      cons req addr        cnt
        vecs[0]  = '{1'b0, 0, 1'b0, 16'h0000, 3'd0, 1'b1, 20'hFFFF0, 3'd0};
        vecs[1]  = '{1'b0, 0, 1'b1, 16'h12EA, 3'd0, 1'b0, 20'hFFFF2, 3'd2};
        vecs[2]  = '{1'b0, 0, 1'b0, 16'h0000, 3'd0, 1'b1, 20'hFFFF2, 3'd2};
        vecs[3]  = '{1'b0, 0, 1'b1, 16'h3434, 3'd0, 1'b0, 20'hFFFF4, 3'd4};
        vecs[4]  = '{1'b0, 0, 1'b0, 16'h0000, 3'd0, 1'b1, 20'hFFFF4, 3'd4};
        vecs[5]  = '{1'b0, 0, 1'b1, 16'h5656, 3'd0, 1'b0, 20'hFFFF6, 3'd6};
        vecs[6]  = '{1'b0, 0, 1'b0, 16'h0000, 3'd0, 1'b0, 20'hFFFF6, 3'd6};
        vecs[7]  = '{1'b0, 0, 1'b0, 16'h0000, 3'd0, 1'b0, 20'hFFFF6, 3'd6};
        vecs[8]  = '{1'b0, 0, 1'b0, 16'h0000, 3'd2, 1'b0, 20'hFFFF6, 3'd4};
        vecs[9]  = '{1'b0, 0, 1'b0, 16'h0000, 3'd0, 1'b1, 20'hFFFF6, 3'd4};
        vecs[10] = '{1'b0, 0, 1'b1, 16'h7878, 3'd0, 1'b0, 20'hFFFF8, 3'd6};
        vecs[11] = '{1'b0, 0, 1'b0, 16'h0000, 3'd4, 1'b0, 20'hFFFF8, 3'd2};
        vecs[12] = '{1'b0, 0, 1'b0, 16'h0000, 3'd0, 1'b1, 20'hFFFF8, 3'd2};

        reset_n        = 1'b0;
        flush          = 1'b0;
        flush_addr     = 20'h0;
        consume        = 3'd0;
        bus.fetch_ack  = 1'b0;
        bus.fetch_data = 16'h0;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        expect_const("reset", 1'b0, 20'hFFFF0, 3'd0);
        chk("reset_window", window, 32'h0);
        chk("reset_byte", 32'(bus.fetch_byte), 32'h0);
        chk("reset_err", 32'(consume_err), 32'h0);

        reset_n = 1'b1;

        // Reset release, word fills up to full, stall, consume-triggered re-issue.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].fl, vecs[i].fa, vecs[i].ack, vecs[i].data, vecs[i].cons);
            expect_const($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                         vecs[i].exp_count);
            if (i == 1) chk("v1_window16", 32'(window[15:0]), 32'h12EA);
        end

        // Flush in IDLE to an odd address: byte fetch, then word fetch.
        step(1'b0, 0, 1'b1, 16'h9A9A, 3'd0);
        step(1'b1, 20'h00101, 1'b0, 16'h0, 3'd0);
        expect_const("flush_idle", 1'b0, 20'h00101, 3'd0);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        expect_const("odd_issue", 1'b1, 20'h00101, 3'd0);
        chk("odd_byte", 32'(bus.fetch_byte), 32'h1);
        step(1'b0, 0, 1'b1, 16'hAB00, 3'd0);
        chk("odd_fill_b0", 32'(window[7:0]), 32'hAB);
        chk("odd_fill_count", 32'(count), 32'd1);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        expect_const("even_issue", 1'b1, 20'h00102, 3'd1);
        chk("even_byte", 32'(bus.fetch_byte), 32'h0);

        // Flush while FETCH pending: bus cycle held, data discarded, redirect on ack.
        step(1'b1, 20'h00200, 1'b0, 16'h0, 3'd0);
        expect_const("discard_hold", 1'b1, 20'h00102, 3'd0);
        step(1'b0, 0, 1'b1, 16'h5555, 3'd0);
        expect_const("discard_ack", 1'b0, 20'h00200, 3'd0);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        expect_const("redirect_issue", 1'b1, 20'h00200, 3'd0);

        // Same-cycle consume and fill.
        step(1'b0, 0, 1'b1, 16'h2211, 3'd0);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        step(1'b0, 0, 1'b1, 16'h4433, 3'd0);
        chk("pre_cf_window", window, 32'h44332211);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        step(1'b0, 0, 1'b1, 16'h6655, 3'd3);
        chk("cf_count", 32'(count), 32'd3);
        chk("cf_window24", 32'(window[23:0]), 32'h665544);

        // Over-consume, then flush near the top of memory and wrap.
        step(1'b0, 0, 1'b0, 16'h0, 3'd2);
        step(1'b0, 0, 1'b0, 16'h0, 3'd3);
        chk("err_pulse", 32'(consume_err), 32'h1);
        chk("err_count", 32'(count), 32'd1);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        chk("err_clear", 32'(consume_err), 32'h0);
        step(1'b1, 20'hFFFFE, 1'b0, 16'h0, 3'd0);
        step(1'b0, 0, 1'b1, 16'hCDCD, 3'd0);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        expect_const("wrap_first", 1'b1, 20'hFFFFE, 3'd0);
        step(1'b0, 0, 1'b1, 16'h0201, 3'd0);
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        expect_const("wrap_second", 1'b1, 20'h00000, 3'd2);

        // Reset mid-fetch: immediate reset values, late ack ignored.
        reset_n       = 1'b0;
        bus.fetch_ack = 1'b1;
        #1;
        expect_const("rst_mid", 1'b0, 20'hFFFF0, 3'd0);
        @(posedge clock);
        #1;
        expect_const("rst_late_ack", 1'b0, 20'hFFFF0, 3'd0);
        bus.fetch_ack = 1'b0;
        reset_n       = 1'b1;
        model_reset();
        step(1'b0, 0, 1'b0, 16'h0, 3'd0);
        expect_const("rst_reissue", 1'b1, 20'hFFFF0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
